// File: rtl/hline_zbuff_pkg.sv
// Shared encodings for the horizontal-span z-buffer controller:
// FSM states, depth-compare function codes and pixel size.
package hline_zbuff_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SETUP,
    S_CHUNK,
    S_LOAD_Z,
    S_LOAD_F,
    S_INTERP,
    S_WR_Z,
    S_WR_F,
    S_DONE
  } state_t;

  localparam logic [1:0] Z_LESS    = 2'd0;
  localparam logic [1:0] Z_LEQUAL  = 2'd1;
  localparam logic [1:0] Z_GREATER = 2'd2;
  localparam logic [1:0] Z_ALWAYS  = 2'd3;

  localparam int BYTES_PER_PIX = 4;

endpackage

// File: rtl/hline_z_interp.sv
// Per-pixel z stepper (integer slope plus Bresenham-style fractional carry)
// and unsigned depth compare of the current z against the z-buffer head.
module hline_z_interp
  import hline_zbuff_pkg::*;
#(
  parameter int ZW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          step,
  input  logic [ZW-1:0] z1,
  input  logic [ZW-1:0] slope,
  input  logic [CW-1:0] err,
  input  logic [CW-1:0] rem,
  input  logic [CW-1:0] dx,
  input  logic [1:0]    z_func,
  input  logic [ZW-1:0] z_in,
  output logic [ZW-1:0] z,
  output logic          pass
);

  logic [CW:0]   e;
  logic [CW:0]   e_sum;
  logic [ZW-1:0] z_carry;

  // The carry step moves one extra unit away from zero in the slope's direction.
  always_comb begin
    e_sum   = e + {1'b0, rem};
    z_carry = slope[ZW-1] ? (slope - ZW'(1)) : (slope + ZW'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e <= '0;
      z <= '0;
    end else if (load) begin
      e <= {1'b0, err};
      z <= z1;
    end else if (step) begin
      if (e_sum >= {1'b0, dx}) begin
        e <= e_sum - {1'b0, dx};
        z <= z + z_carry;
      end else begin
        e <= e_sum;
        z <= z + slope;
      end
    end
  end

  always_comb begin
    pass = 1'b0;
    case (z_func)
      Z_LESS:    pass = (z < z_in);
      Z_LEQUAL:  pass = (z <= z_in);
      Z_GREATER: pass = (z > z_in);
      Z_ALWAYS:  pass = 1'b1;
      default:   pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/hline_zbuff_ctrl.sv
// Horizontal-span z-buffer controller: bursts a span, reads z/colour lines, depth-tests and
// writes merged lines back. Define HLINE_ZBUFF_STATS_EN to enable pass/fail pixel counters.
module hline_zbuff_ctrl
  import hline_zbuff_pkg::*;
#(
  parameter int MAX_BURST = 256,
  parameter int ZW        = 32,
  parameter int AW        = 32,
  parameter int CW        = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] fb_addr,
  input  logic [AW-1:0] zbuff_addr,
  input  logic [CW-1:0] dx,
  input  logic [ZW-1:0] z1,
  input  logic [ZW-1:0] slope,
  input  logic [CW-1:0] rem,
  input  logic [CW-1:0] err,
  input  logic [31:0]   rgbx,
  input  logic [1:0]    z_func,
  output logic          rd_req,
  output logic          wr_req,
  output logic [AW-1:0] addr,
  output logic [8:0]    burst_len,
  input  logic          rd_beat,
  input  logic          bus_done,
  output logic          to_z_fifo,
  output logic          to_f_fifo,
  output logic          pop_in,
  input  logic [ZW-1:0] z_fifo_in,
  input  logic [31:0]   f_fifo_in,
  output logic          push_out,
  output logic [ZW-1:0] z_out,
  output logic [31:0]   f_out,
  output logic          be_out,
  output logic          drain_z,
  output logic          drain_f,
  output logic          busy,
  output logic          done,
  output logic [31:0]   pass_cnt,
  output logic [31:0]   fail_cnt
);

  state_t        state, next_state;
  logic [CW-1:0] remaining;
  logic [AW-1:0] offset;
  logic [8:0]    len;
  logic [8:0]    beat_cnt;
  logic [8:0]    pix_cnt;
  logic          done_seen;
  logic [8:0]    chunk_len;
  logic          load_done;
  logic          interp;
  logic          pass;
  logic [ZW-1:0] z_cur;
  logic [AW-1:0] base_sel;

  assign chunk_len = (remaining > CW'(MAX_BURST)) ? 9'(MAX_BURST) : 9'(remaining);
  // A read burst ends once all len beats landed and the bus has signalled completion, in either order.
  assign load_done = ((beat_cnt == len) || (rd_beat && (beat_cnt == len - 9'd1)))
                     && (bus_done || done_seen);
  assign interp    = (state == S_INTERP);
  assign burst_len = len;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    rd_req     = 1'b0;
    wr_req     = 1'b0;
    to_z_fifo  = 1'b0;
    to_f_fifo  = 1'b0;
    pop_in     = 1'b0;
    push_out   = 1'b0;
    drain_z    = 1'b0;
    drain_f    = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    base_sel   = zbuff_addr;
    addr       = '0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) next_state = S_SETUP;
      end
      S_SETUP: next_state = S_CHUNK;
      S_CHUNK: next_state = (remaining == '0) ? S_DONE : S_LOAD_Z;
      S_LOAD_Z: begin
        rd_req    = 1'b1;
        to_z_fifo = 1'b1;
        addr      = zbuff_addr + offset;
        if (load_done) next_state = S_LOAD_F;
      end
      S_LOAD_F: begin
        rd_req    = 1'b1;
        to_f_fifo = 1'b1;
        base_sel  = fb_addr;
        addr      = base_sel + offset;
        if (load_done) next_state = S_INTERP;
      end
      S_INTERP: begin
        pop_in   = 1'b1;
        push_out = 1'b1;
        if (pix_cnt == len - 9'd1) next_state = S_WR_Z;
      end
      S_WR_Z: begin
        wr_req  = 1'b1;
        drain_z = 1'b1;
        addr    = zbuff_addr + offset;
        if (bus_done) next_state = S_WR_F;
      end
      S_WR_F: begin
        wr_req   = 1'b1;
        drain_f  = 1'b1;
        base_sel = fb_addr;
        addr     = base_sel + offset;
        if (bus_done) next_state = S_CHUNK;
      end
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (start) next_state = S_SETUP;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      remaining <= '0;
      offset    <= '0;
      len       <= '0;
      beat_cnt  <= '0;
      pix_cnt   <= '0;
      done_seen <= 1'b0;
    end else begin
      case (state)
        S_SETUP: begin
          remaining <= dx;
          offset    <= '0;
        end
        S_CHUNK: begin
          if (remaining != '0) len <= chunk_len;
          remaining <= remaining - CW'(chunk_len);
          beat_cnt  <= '0;
          pix_cnt   <= '0;
          done_seen <= 1'b0;
        end
        S_LOAD_Z, S_LOAD_F: begin
          if (load_done) begin
            beat_cnt  <= '0;
            done_seen <= 1'b0;
          end else begin
            if (rd_beat && (beat_cnt != len)) beat_cnt <= beat_cnt + 9'd1;
            if (bus_done) done_seen <= 1'b1;
          end
        end
        S_INTERP: pix_cnt <= pix_cnt + 9'd1;
        S_WR_F: if (bus_done) offset <= offset + AW'(len) * AW'(BYTES_PER_PIX);
        default: ;
      endcase
    end
  end

  hline_z_interp #(.ZW(ZW), .CW(CW)) u_interp (
    .clk    (clk),
    .reset  (reset),
    .load   (state == S_SETUP),
    .step   (interp),
    .z1     (z1),
    .slope  (slope),
    .err    (err),
    .rem    (rem),
    .dx     (dx),
    .z_func (z_func),
    .z_in   (z_fifo_in),
    .z      (z_cur),
    .pass   (pass)
  );

  assign z_out  = interp ? (pass ? z_cur : z_fifo_in) : '0;
  assign f_out  = interp ? (pass ? rgbx : f_fifo_in) : '0;
  assign be_out = interp & pass;

`ifdef HLINE_ZBUFF_STATS_EN
  // Counters saturate rather than wrap so long runs stay monotonic.
  always_ff @(posedge clk) begin
    if (reset || (state == S_SETUP)) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else if (push_out) begin
      if (be_out && (pass_cnt != '1)) pass_cnt <= pass_cnt + 32'd1;
      if (!be_out && (fail_cnt != '1)) fail_cnt <= fail_cnt + 32'd1;
    end
  end
`else
  assign pass_cnt = '0;
  assign fail_cnt = '0;
`endif

endmodule

// File: tb/tb_hline_zbuff_ctrl.sv
// Self-checking bench for hline_zbuff_ctrl: a word memory with an AXI-like responder,
// and a pixel-level reference model of the span depth test.
`timescale 1ns/1ps
module tb_hline_zbuff_ctrl;

  localparam int ZW = 32;
  localparam int AW = 32;
  localparam int CW = 16;
  localparam int MEM_WORDS = 8192;
  localparam logic [AW-1:0] ZB_BASE = 32'h0000_0000;
  localparam logic [AW-1:0] FB_BASE = 32'h0000_4000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] fb_addr = '0, zbuff_addr = '0;
  logic [CW-1:0] dx = '0, rem = '0, err = '0;
  logic [ZW-1:0] z1 = '0, slope = '0;
  logic [31:0]   rgbx = '0;
  logic [1:0]    z_func = '0;
  logic          rd_req, wr_req, to_z_fifo, to_f_fifo, pop_in, push_out, be_out;
  logic          drain_z, drain_f, busy, done;
  logic [AW-1:0] addr;
  logic [8:0]    burst_len;
  logic          rd_beat = 1'b0, bus_done = 1'b0;
  logic [ZW-1:0] z_fifo_in = '0, z_out;
  logic [31:0]   f_fifo_in = '0, f_out, pass_cnt, fail_cnt;

  hline_zbuff_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .fb_addr(fb_addr), .zbuff_addr(zbuff_addr),
    .dx(dx), .z1(z1), .slope(slope), .rem(rem), .err(err), .rgbx(rgbx), .z_func(z_func),
    .rd_req(rd_req), .wr_req(wr_req), .addr(addr), .burst_len(burst_len),
    .rd_beat(rd_beat), .bus_done(bus_done), .to_z_fifo(to_z_fifo), .to_f_fifo(to_f_fifo),
    .pop_in(pop_in), .z_fifo_in(z_fifo_in), .f_fifo_in(f_fifo_in), .push_out(push_out),
    .z_out(z_out), .f_out(f_out), .be_out(be_out), .drain_z(drain_z), .drain_f(drain_f),
    .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [31:0] z; logic [31:0] f; logic be;} pix_t;
  typedef struct packed {logic wr; logic isf; logic [31:0] a; logic [8:0] len;} burst_t;

  logic [31:0] mem     [MEM_WORDS];
  logic [31:0] exp_mem [MEM_WORDS];
  logic [31:0] zq[$], fq[$], outz[$], outf[$];
  logic        outbz[$], outbf[$];
  pix_t        plog[$], exp_pix[$];
  burst_t      blog[$];
  int          exp_pass;
  logic        pop_pending = 1'b0;
  logic        any_req = 1'b0;
  int          n_assert = 0;
  int          n_fail = 0;

  function automatic int widx(input logic [31:0] a);
    return int'(a[14:2]);
  endfunction

  // Posedge monitor: log pushes into the out-FIFOs and note pops of the in-FIFOs
  always @(posedge clk) begin
    if (rd_req || wr_req) any_req = 1'b1;
    if (push_out) begin
      plog.push_back('{z: z_out, f: f_out, be: be_out});
      outz.push_back(z_out);  outbz.push_back(be_out);
      outf.push_back(f_out);  outbf.push_back(be_out);
    end
    if (pop_in) pop_pending = 1'b1;
  end

  // Negedge bus responder: read beats from memory into the in-FIFOs, write bursts from the out-FIFOs
  int          r_cnt = 0, r_len = 0, r_wait = 0;
  logic        r_active = 1'b0, r_wr = 1'b0, r_isf = 1'b0;
  logic [31:0] r_base = '0;
  always @(negedge clk) begin
    rd_beat  = 1'b0;
    bus_done = 1'b0;
    if (pop_pending) begin
      if (zq.size() > 0) void'(zq.pop_front());
      if (fq.size() > 0) void'(fq.pop_front());
      pop_pending = 1'b0;
    end
    if (reset || (!rd_req && !wr_req)) begin
      r_active = 1'b0;
    end else if (!r_active) begin
      r_active = 1'b1;
      r_wr     = wr_req;
      r_isf    = rd_req ? to_f_fifo : drain_f;
      r_base   = addr;
      r_len    = int'(burst_len);
      r_cnt    = 0;
      r_wait   = int'($urandom_range(0, 2));
      blog.push_back('{wr: r_wr, isf: r_isf, a: addr, len: burst_len});
      if (r_wr) begin
        for (int i = 0; i < r_len; i++) begin
          if (r_isf) begin
            if (outf.size() > 0) begin
              if (outbf[0]) mem[(widx(r_base) + i) % MEM_WORDS] = outf[0];
              void'(outf.pop_front()); void'(outbf.pop_front());
            end
          end else begin
            if (outz.size() > 0) begin
              if (outbz[0]) mem[(widx(r_base) + i) % MEM_WORDS] = outz[0];
              void'(outz.pop_front()); void'(outbz.pop_front());
            end
          end
        end
        r_cnt = r_len;
      end
    end
    if (r_active) begin
      if (!r_wr && (r_cnt < r_len)) begin
        rd_beat = 1'b1;
        if (r_isf) fq.push_back(mem[(widx(r_base) + r_cnt) % MEM_WORDS]);
        else       zq.push_back(mem[(widx(r_base) + r_cnt) % MEM_WORDS]);
        r_cnt++;
      end else if (r_wait > 0) begin
        r_wait--;
      end else begin
        bus_done = 1'b1;
        r_active = 1'b0;
      end
    end
    z_fifo_in = (zq.size() > 0) ? zq[0] : '0;
    f_fifo_in = (fq.size() > 0) ? fq[0] : '0;
  end

  task automatic checkOutput(input string tag, input logic [71:0] obs, input logic [71:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_bench();
    zq.delete(); fq.delete(); outz.delete(); outf.delete(); outbz.delete(); outbf.delete();
    plog.delete(); blog.delete();
    pop_pending = 1'b0;
    any_req = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] zb, input logic [31:0] fb, input int n,
                               input logic [31:0] z0, input logic [31:0] sl, input int rm,
                               input int er, input logic [31:0] col, input logic [1:0] zf);
    @(negedge clk);
    zbuff_addr = zb; fb_addr = fb; dx = CW'(n); z1 = z0; slope = sl;
    rem = CW'(rm); err = CW'(er); rgbx = col; z_func = zf;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Pixel-by-pixel reference: interpolate z, depth test, merge into a copy of memory
  task automatic model_span(input logic [31:0] zb, input logic [31:0] fb, input int n,
                            input logic [31:0] z0, input logic [31:0] sl, input int rm,
                            input int er, input logic [31:0] col, input logic [1:0] zf);
    logic [31:0] z, zold, fold;
    logic        p;
    int          e, zi, fi;
    exp_pix.delete();
    exp_pass = 0;
    exp_mem  = mem;
    z = z0;
    e = er;
    for (int i = 0; i < n; i++) begin
      zi = (widx(zb) + i) % MEM_WORDS;
      fi = (widx(fb) + i) % MEM_WORDS;
      zold = exp_mem[zi];
      fold = exp_mem[fi];
      case (zf)
        2'd0:    p = (z < zold);
        2'd1:    p = (z <= zold);
        2'd2:    p = (z > zold);
        default: p = 1'b1;
      endcase
      if (p) begin
        exp_pix.push_back('{z: z, f: col, be: 1'b1});
        exp_mem[zi] = z;
        exp_mem[fi] = col;
        exp_pass++;
      end else begin
        exp_pix.push_back('{z: zold, f: fold, be: 1'b0});
      end
      e = e + rm;
      if (e >= n) begin
        e = e - n;
        z = z + sl + (sl[31] ? 32'hFFFF_FFFF : 32'd1);
      end else begin
        z = z + sl;
      end
    end
  endtask

  task automatic run_span(input string tag, input logic [31:0] zb, input logic [31:0] fb,
                          input int n, input logic [31:0] z0, input logic [31:0] sl,
                          input int rm, input int er, input logic [31:0] col, input logic [1:0] zf);
    int cyc;
    model_span(zb, fb, n, z0, sl, rm, er, col, zf);
    clear_bench();
    applyStimulus(zb, fb, n, z0, sl, rm, er, col, zf);
    cyc = 0;
    while (!done && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput({tag, "_done"}, 72'(done), 72'(1));
    checkOutput({tag, "_npix"}, 72'(plog.size()), 72'(exp_pix.size()));
    for (int i = 0; i < exp_pix.size() && i < plog.size(); i++)
      checkOutput($sformatf("%s_pix%0d", tag, i), 72'(plog[i]), 72'(exp_pix[i]));
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("%s_mem%0d", tag, i),
                  {8'h0, mem[(widx(zb) + i) % MEM_WORDS], mem[(widx(fb) + i) % MEM_WORDS]},
                  {8'h0, exp_mem[(widx(zb) + i) % MEM_WORDS], exp_mem[(widx(fb) + i) % MEM_WORDS]});
`ifdef HLINE_ZBUFF_STATS_EN
    checkOutput({tag, "_pass_cnt"}, 72'(pass_cnt), 72'(exp_pass));
    checkOutput({tag, "_fail_cnt"}, 72'(fail_cnt), 72'(n - exp_pass));
`else
    checkOutput({tag, "_pass_cnt"}, 72'(pass_cnt), 72'(0));
    checkOutput({tag, "_fail_cnt"}, 72'(fail_cnt), 72'(0));
`endif
  endtask

  initial begin
    #900us;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          cyc, n, off, zoff, foff;
    logic [31:0] col;
    logic [3:0]  exp_be;
    int          exp_lens [3];
    logic        all_be, all_col;

    for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;

    // Reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_rd_req", 72'(rd_req), 72'(0));
    checkOutput("rst_wr_req", 72'(wr_req), 72'(0));
    checkOutput("rst_busy", 72'(busy), 72'(0));
    checkOutput("rst_done", 72'(done), 72'(0));
    checkOutput("rst_push", 72'({push_out, pop_in, be_out}), 72'(0));
    checkOutput("rst_addr", 72'(addr), 72'(0));
    checkOutput("rst_len", 72'(burst_len), 72'(0));
    checkOutput("rst_cnts", 72'({pass_cnt, fail_cnt}), 72'(0));

    // Empty span: no bus traffic, done within three cycles
    clear_bench();
    applyStimulus(ZB_BASE, FB_BASE, 0, 32'd5, 32'd1, 0, 0, 32'h1234_5678, 2'd0);
    cyc = 1;
    while (!done && cyc < 3) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("dx0_done", 72'(done), 72'(1));
    checkOutput("dx0_noreq", 72'(any_req), 72'(0));
    checkOutput("dx0_nopix", 72'(plog.size()), 72'(0));

    // Directed interpolation with LESS against a flat z-buffer of 13
    for (int i = 0; i < 4; i++) mem[widx(ZB_BASE) + i] = 32'd13;
    run_span("dir", ZB_BASE, FB_BASE, 4, 32'd10, 32'd2, 1, 0, 32'hAABB_CCDD, 2'd0);
    exp_be = 4'b0011;
    for (int i = 0; i < 4 && i < plog.size(); i++)
      checkOutput($sformatf("dir_be%0d", i), 72'(plog[i].be), 72'(exp_be[i]));
    checkOutput("dir_zmem1", 72'(mem[widx(ZB_BASE) + 1]), 72'(12));
    checkOutput("dir_zmem3", 72'(mem[widx(ZB_BASE) + 3]), 72'(13));

    // Long span split into 256/256/88 bursts
    run_span("long", ZB_BASE, FB_BASE, 600, $urandom, $urandom_range(0, 50), 7, 3,
             $urandom, 2'($urandom_range(0, 3)));
    exp_lens[0] = 256; exp_lens[1] = 256; exp_lens[2] = 88;
    checkOutput("long_nburst", 72'(blog.size()), 72'(12));
    off = 0;
    for (int k = 0; k < 3; k++) begin
      if (blog.size() == 12) begin
        checkOutput($sformatf("long_rz%0d", k), 72'(blog[4*k]),
                    72'(burst_t'{wr: 1'b0, isf: 1'b0, a: ZB_BASE + off, len: 9'(exp_lens[k])}));
        checkOutput($sformatf("long_rf%0d", k), 72'(blog[4*k+1]),
                    72'(burst_t'{wr: 1'b0, isf: 1'b1, a: FB_BASE + off, len: 9'(exp_lens[k])}));
        checkOutput($sformatf("long_wz%0d", k), 72'(blog[4*k+2]),
                    72'(burst_t'{wr: 1'b1, isf: 1'b0, a: ZB_BASE + off, len: 9'(exp_lens[k])}));
        checkOutput($sformatf("long_wf%0d", k), 72'(blog[4*k+3]),
                    72'(burst_t'{wr: 1'b1, isf: 1'b1, a: FB_BASE + off, len: 9'(exp_lens[k])}));
      end
      off += 1024 * (k == 0 || k == 1 ? 1 : 0) + (k == 2 ? 0 : 0);
    end

    // ALWAYS passes every pixel with the span colour
    n   = int'($urandom_range(1, 300));
    col = $urandom;
    for (int i = 0; i < n; i++) mem[widx(ZB_BASE) + i] = $urandom;
    run_span("always", ZB_BASE, FB_BASE, n, $urandom, $urandom, int'($urandom_range(0, n - 1)),
             0, col, 2'd3);
    all_be  = 1'b1;
    all_col = 1'b1;
    foreach (plog[i]) begin
      all_be  &= plog[i].be;
      all_col &= (plog[i].f == col);
    end
    checkOutput("always_be", 72'(all_be), 72'(1));
    checkOutput("always_col", 72'(all_col), 72'(1));

    // Random spans with signed slopes, fractional steps and random compare functions
    for (int t = 0; t < 4; t++) begin
      n    = int'($urandom_range(1, 700));
      zoff = int'($urandom_range(0, 1000));
      foff = int'($urandom_range(0, 1000));
      run_span($sformatf("rnd%0d", t), ZB_BASE + 32'(4 * zoff), FB_BASE + 32'(4 * foff), n,
               $urandom, $urandom, int'($urandom_range(0, n - 1)), int'($urandom_range(0, n - 1)),
               $urandom, 2'($urandom_range(0, 3)));
    end

    // Reset during LOAD_F abandons the burst; a fresh start then completes normally
    clear_bench();
    applyStimulus(ZB_BASE, FB_BASE, 40, 32'd100, 32'd3, 1, 0, 32'h0F0F_0F0F, 2'd1);
    cyc = 0;
    while (!to_f_fifo && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("rstmid_reach_loadf", 72'(to_f_fifo), 72'(1));
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rstmid_rd_req", 72'(rd_req), 72'(0));
    checkOutput("rstmid_idle", 72'({busy, done, to_f_fifo}), 72'(0));
    reset = 1'b0;
    repeat (2) @(negedge clk);
    run_span("rstmid_rerun", ZB_BASE, FB_BASE, 40, 32'd100, 32'd3, 1, 0, 32'h0F0F_0F0F, 2'd1);

    // Eight-pixel span with exactly three passing pixels
    for (int i = 0; i < 8; i++) mem[widx(ZB_BASE) + i] = (i < 3) ? 32'd100 : 32'd0;
    run_span("stats", ZB_BASE, FB_BASE, 8, 32'd0, 32'd1, 0, 0, 32'h5555_AAAA, 2'd0);
`ifdef HLINE_ZBUFF_STATS_EN
    checkOutput("stats_pass3", 72'(pass_cnt), 72'(3));
    checkOutput("stats_fail5", 72'(fail_cnt), 72'(5));
`else
    checkOutput("stats_pass0", 72'(pass_cnt), 72'(0));
    checkOutput("stats_fail0", 72'(fail_cnt), 72'(0));
`endif

    // start while busy is ignored: the span length latched at the first start governs
    model_span(ZB_BASE, FB_BASE, 5, 32'd7, 32'd1, 0, 0, 32'h0BAD_F00D, 2'd3);
    clear_bench();
    applyStimulus(ZB_BASE, FB_BASE, 5, 32'd7, 32'd1, 0, 0, 32'h0BAD_F00D, 2'd3);
    repeat (3) @(negedge clk);
    applyStimulus(ZB_BASE, FB_BASE, 9, 32'd7, 32'd1, 0, 0, 32'h0BAD_F00D, 2'd3);
    cyc = 0;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("busy_start_done", 72'(done), 72'(1));
    checkOutput("busy_start_npix", 72'(plog.size()), 72'(exp_pix.size()));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
